// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends marker 1,1,0, then DATA_W payload bits MSB first,
// then IDLE_BITS guard zeros, advancing one bit per bit_en strobe.
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int IDLE_BITS = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              x_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_N = (DATA_W > IDLE_BITS) ? ((DATA_W > 3) ? DATA_W : 3)
                                                : ((IDLE_BITS > 3) ? IDLE_BITS : 3);
    localparam int CW    = $clog2(MAX_N) + 1;

    // Handshake: a word transfers on any clk edge where tx_valid and tx_ready are
    // both high; tx_ready is a pure decode of IDLE, so upstream may hold tx_valid.
    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              x_nxt;
    logic              done_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            x_out      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            x_out      <= x_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        x_nxt     = x_out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // bit_en plays no part here; the first marker bit waits for a later strobe
                x_nxt = 1'b0;
                if (tx_valid) begin
                    shreg_nxt = tx_data;
                    cnt_nxt   = '0;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (bit_en) begin
                    x_nxt = (cnt != CW'(2));
                    if (cnt == CW'(2)) begin
                        cnt_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (bit_en) begin
                    x_nxt     = shreg[DATA_W-1];
                    shreg_nxt = shreg << 1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            GAP: begin
                if (bit_en) begin
                    x_nxt = 1'b0;
                    if (cnt == CW'(IDLE_BITS - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                x_nxt     = 1'b0;
            end
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
